// File: rtl/pc_seq_unit.sv
// pc_seq_unit: multi-cycle program-counter sequencer.
//
// Holds the architectural PC. It issues one fetch request per instruction over
// a valid/ready handshake. It then waits for the execute stage to retire that
// instruction and commits the next PC, which depends on the redirect kind.
// A circular return-address stack (RAS) follows call/return nesting. In this
// generation the RAS is only observed and does not steer npc.
//
// Handshake: a fetch transfer happens on any rising clk edge where both
// fetch_valid and fetch_ready are high. fetch_valid and fetch_pc stay stable
// until that transfer happens. exec_valid is a one-cycle strobe and is only
// honoured while the unit is waiting in S_EXEC.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   fetch_valid/fetch_ready  fetch request handshake
//   fetch_pc                 address to fetch (equals pc)
//   exec_valid               execute stage retires the instruction at pc
//   exec_kind                000 seq, 001 jal, 010 jalr, 011 branch, 100 csr/trap
//   exec_taken               branch outcome (kind 011 only)
//   exec_offset, exec_src1   immediate and rs1 value for target computation
//   exec_csr_pc              mtvec/mepc target for csr/trap
//   exec_is_call/is_ret      RAS push/pop qualifiers
//   pc, npc                  current PC; combinational next PC
//   misaligned               one-cycle pulse after a misaligned commit
//   ras_top, ras_count       RAS top entry (0 when empty) and occupancy
//   ras_overflow/underflow   sticky RAS error flags
//   dbg_state_o              FSM state (0 = S_FETCH, 1 = S_EXEC)
module pc_seq_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 'h8000_0000,
    parameter int              INST_BYTES = 4,
    parameter int              RAS_DEPTH  = 8,
    localparam int             CW         = $clog2(RAS_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    input  logic            exec_valid,
    input  logic [2:0]      exec_kind,
    input  logic            exec_taken,
    input  logic [XLEN-1:0] exec_offset,
    input  logic [XLEN-1:0] exec_src1,
    input  logic [XLEN-1:0] exec_csr_pc,
    input  logic            exec_is_call,
    input  logic            exec_is_ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc,
    output logic            misaligned,
    output logic [XLEN-1:0] ras_top,
    output logic [CW-1:0]   ras_count,
    output logic            ras_overflow,
    output logic            ras_underflow,
    output logic            dbg_state_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [XLEN-1:0] STEP       = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(RAS_DEPTH);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic            misaligned_q;
    logic            commit;

    logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;          // next free slot (one past the top)
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic            ras_we;
    logic [PW-1:0]   ras_waddr;
    logic [PW-1:0]   top_idx;
    logic            ras_empty;
    logic            ras_full;

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] jalr_sum;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        fetch_valid = 1'b0;
        commit      = 1'b0;
        case (state_q)
            S_FETCH: begin
                // The request is withheld while reset is applied.
                fetch_valid = !rst;
                if (fetch_ready && !rst) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (exec_valid) begin
                    commit  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-PC computation (all sums wrap modulo 2^XLEN)
    // ------------------------------------------------------------------
    assign seq_pc   = pc_q + STEP;
    assign jalr_sum = exec_src1 + exec_offset;

    always_comb begin
        npc = seq_pc;
        case (exec_kind)
            3'b001:  npc = pc_q + exec_offset;
            3'b010:  npc = {jalr_sum[XLEN-1:1], 1'b0};
            3'b011:  npc = exec_taken ? (pc_q + exec_offset) : seq_pc;
            3'b100:  npc = exec_csr_pc;
            default: npc = seq_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            if (commit) pc_q <= npc;
            // Report only. The PC still moves to the misaligned target,
            // and the CSR unit raises the trap.
            misaligned_q <= commit && ((npc & ALIGN_MASK) != '0);
        end
    end

    // ------------------------------------------------------------------
    // Return-address stack
    // ------------------------------------------------------------------
    assign top_idx   = ptr_q - 1'b1;
    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == FULL_COUNT);

    always_comb begin
        ptr_d     = ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        ras_we    = 1'b0;
        ras_waddr = ptr_q;
        if (commit) begin
            case ({exec_is_call, exec_is_ret})
                2'b10: begin
                    // When full, the write slot is the oldest entry, so a
                    // push overwrites it and the count stays at the maximum.
                    ras_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (ras_full) ovf_d   = 1'b1;
                    else          count_d = count_q + 1'b1;
                end
                2'b01: begin
                    if (ras_empty) begin
                        udf_d = 1'b1;
                    end else begin
                        ptr_d   = ptr_q - 1'b1;
                        count_d = count_q - 1'b1;
                    end
                end
                2'b11: begin
                    // Coroutine jump: pop then push, which replaces the top
                    // entry in place. An empty stack only takes the push.
                    ras_we = 1'b1;
                    if (ras_empty) begin
                        ptr_d   = ptr_q + 1'b1;
                        count_d = count_q + 1'b1;
                        udf_d   = 1'b1;
                    end else begin
                        ras_waddr = top_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage has no reset. An entry is only read when count covers it.
    always_ff @(posedge clk) begin
        if (ras_we && !rst) ras_mem_q[ras_waddr] <= seq_pc;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc            = pc_q;
    assign fetch_pc      = pc_q;
    assign misaligned    = misaligned_q;
    assign ras_top       = ras_empty ? '0 : ras_mem_q[top_idx];
    assign ras_count     = count_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = udf_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
module tb_pc_seq_unit;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        exec_valid;
  logic [2:0]  exec_kind;
  logic        exec_taken;
  logic [31:0] exec_offset;
  logic [31:0] exec_src1;
  logic [31:0] exec_csr_pc;
  logic        exec_is_call;
  logic        exec_is_ret;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        misaligned;
  logic [31:0] ras_top;
  logic [3:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;
  logic        dbg_state;

  int tests_run;
  int tests_failed;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf;
  logic        m_udf;
  logic [31:0] exp_q[$];

  pc_seq_unit dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_pc     (fetch_pc),
    .exec_valid   (exec_valid),
    .exec_kind    (exec_kind),
    .exec_taken   (exec_taken),
    .exec_offset  (exec_offset),
    .exec_src1    (exec_src1),
    .exec_csr_pc  (exec_csr_pc),
    .exec_is_call (exec_is_call),
    .exec_is_ret  (exec_is_ret),
    .pc           (pc),
    .npc          (npc),
    .misaligned   (misaligned),
    .ras_top      (ras_top),
    .ras_count    (ras_count),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ras(input string tag);
    logic [31:0] top;
    top = (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size() - 1];
    check({tag, "_cnt"}, {28'h0, ras_count}, m_ras.size());
    check({tag, "_top"}, ras_top, top);
    check({tag, "_ovf"}, {31'h0, ras_overflow}, {31'h0, m_ovf});
    check({tag, "_udf"}, {31'h0, ras_underflow}, {31'h0, m_udf});
  endtask

  task automatic model_reset();
    m_pc = 32'h8000_0000;
    m_ras.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic idle_inputs();
    fetch_ready  = 1'b0;
    exec_valid   = 1'b0;
    exec_kind    = 3'b000;
    exec_taken   = 1'b0;
    exec_offset  = 32'h0;
    exec_src1    = 32'h0;
    exec_csr_pc  = 32'h0;
    exec_is_call = 1'b0;
    exec_is_ret  = 1'b0;
  endtask

  // ---------------- driver: one full instruction ----------------
  // Called at a falling edge with the DUT in S_FETCH.
  task automatic run_instr(input string tag, input logic [2:0] kind, input logic taken,
                           input logic [31:0] off, input logic [31:0] src1,
                           input logic [31:0] csr, input logic call, input logic ret);
    logic [31:0] seq;
    logic [31:0] exp_npc;
    logic [31:0] got;
    check({tag, "_fv_fetch"}, {31'h0, fetch_valid}, 32'h1);
    check({tag, "_fetch_pc"}, fetch_pc, m_pc);
    fetch_ready = 1'b1;
    @(negedge clk);
    fetch_ready = 1'b0;
    check({tag, "_fv_exec"}, {31'h0, fetch_valid}, 32'h0);
    check({tag, "_mis_idle"}, {31'h0, misaligned}, 32'h0);

    seq = m_pc + 32'd4;
    case (kind)
      3'b001:  exp_npc = m_pc + off;
      3'b010:  exp_npc = (src1 + off) & ~32'h1;
      3'b011:  exp_npc = taken ? m_pc + off : seq;
      3'b100:  exp_npc = csr;
      default: exp_npc = seq;
    endcase
    exp_q.push_back(exp_npc);

    exec_kind    = kind;
    exec_taken   = taken;
    exec_offset  = off;
    exec_src1    = src1;
    exec_csr_pc  = csr;
    exec_is_call = call;
    exec_is_ret  = ret;
    exec_valid   = 1'b1;
    #1;
    check({tag, "_npc"}, npc, exp_npc);
    @(negedge clk);
    idle_inputs();

    // RAS model
    if (call && !ret) begin
      if (m_ras.size() == 8) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      m_ras.push_back(seq);
    end else if (ret && !call) begin
      if (m_ras.size() == 0) m_udf = 1'b1;
      else void'(m_ras.pop_back());
    end else if (call && ret) begin
      if (m_ras.size() == 0) m_udf = 1'b1;
      else void'(m_ras.pop_back());
      m_ras.push_back(seq);
    end

    got = exp_q.pop_front();
    m_pc = got;
    check({tag, "_pc"}, pc, got);
    check({tag, "_mis"}, {31'h0, misaligned}, {31'h0, (got[1:0] != 2'b00)});
    check({tag, "_state"}, {31'h0, dbg_state}, 32'h0);
    check_ras(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle_inputs();
    rst = 1'b1;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_fv_during", {31'h0, fetch_valid}, 32'h0);
    check("rst_pc", pc, 32'h8000_0000);
    rst = 1'b0;
    #1;
    check("rst_state", {31'h0, dbg_state}, 32'h0);
    check("rst_fv", {31'h0, fetch_valid}, 32'h1);
    check("rst_mis", {31'h0, misaligned}, 32'h0);
    check_ras("rst");

    // Three sequential instructions
    for (int i = 0; i < 3; i++) run_instr("seq", 3'b000, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("seq_pc_final", pc, 32'h8000_000C);

    // Stall with fetch_ready low, exec_valid pulsed in S_FETCH is ignored
    exp_q.push_back(m_pc);
    for (int i = 0; i < 5; i++) begin
      check("stall_fv", {31'h0, fetch_valid}, 32'h1);
      check("stall_fetch_pc", fetch_pc, 32'h8000_000C);
      if (i == 2) begin
        exec_valid   = 1'b1;
        exec_kind    = 3'b100;
        exec_csr_pc  = 32'h1234_5678;
        exec_is_call = 1'b1;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
    end
    idle_inputs();
    check("stall_pc", pc, exp_q.pop_front());
    check_ras("stall");

    // jalr to an odd target: bit 0 cleared, still misaligned for 4-byte fetch
    run_instr("jalr", 3'b010, 1'b0, 32'd4, 32'h8000_1003, 0, 1'b0, 1'b0);
    check("jalr_target", pc, 32'h8000_1006);
    run_instr("csr_align", 3'b100, 1'b0, 0, 0, 32'h8000_2000, 1'b0, 1'b0);
    run_instr("br_nt", 3'b011, 1'b0, -32'sd8, 0, 0, 1'b0, 1'b0);
    check("br_nt_pc", pc, 32'h8000_2004);
    run_instr("br_t", 3'b011, 1'b1, -32'sd8, 0, 0, 1'b0, 1'b0);
    check("br_t_pc", pc, 32'h8000_1FFC);

    // Wrap-around
    run_instr("csr_hi", 3'b100, 1'b0, 0, 0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    run_instr("jal_wrap", 3'b001, 1'b0, 32'd8, 0, 0, 1'b0, 1'b0);
    check("jal_wrap_pc", pc, 32'h0000_0004);
    run_instr("kind7", 3'b111, 1'b1, 32'h100, 0, 0, 1'b0, 1'b0);
    run_instr("csr_back", 3'b100, 1'b0, 0, 0, 32'h8000_0000, 1'b0, 1'b0);

    // RAS: 9 calls overflow, 8 rets drain, 1 extra ret underflows
    for (int i = 0; i < 9; i++) run_instr("call", 3'b001, 1'b0, 32'h40, 0, 0, 1'b1, 1'b0);
    check("ovf_cnt", {28'h0, ras_count}, 32'd8);
    check("ovf_flag", {31'h0, ras_overflow}, 32'h1);
    for (int i = 0; i < 8; i++)
      run_instr("ret", 3'b010, 1'b0, 0, m_ras[m_ras.size() - 1], 0, 1'b0, 1'b1);
    check("drain_cnt", {28'h0, ras_count}, 32'd0);
    run_instr("ret_empty", 3'b010, 1'b0, 0, 32'h8000_0100, 0, 1'b0, 1'b1);
    check("udf_flag", {31'h0, ras_underflow}, 32'h1);

    // Coroutine jump at depth 3
    for (int i = 0; i < 3; i++) run_instr("call3", 3'b001, 1'b0, 32'h20, 0, 0, 1'b1, 1'b0);
    run_instr("coro", 3'b010, 1'b0, 0, 32'h8000_4000, 0, 1'b1, 1'b1);
    check("coro_cnt", {28'h0, ras_count}, 32'd3);

    // Randomised mix
    for (int i = 0; i < 8; i++)
      run_instr("rand", 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                {$urandom_range(0, 32'hFFFF), 2'b00} - 32'h2_0000, $urandom,
                {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset in S_EXEC with a retirement pending
    fetch_ready = 1'b1;
    @(negedge clk);
    fetch_ready  = 1'b0;
    exec_valid   = 1'b1;
    exec_kind    = 3'b001;
    exec_offset  = 32'h400;
    exec_is_call = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check("mid_rst_pc", pc, 32'h8000_0000);
    check("mid_rst_state", {31'h0, dbg_state}, 32'h0);
    check("mid_rst_mis", {31'h0, misaligned}, 32'h0);
    check_ras("mid_rst");
    @(negedge clk);
    run_instr("post_rst", 3'b000, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
